// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input row of an N_IN-input Boolean function.
// Each row is held for SETTLE cycles and then the implementation outputs are sampled.
// The sweep captures the truth table from f_in[0] and flags rows where the
// implementations disagree with each other or with the latched expected table.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int N_IMPL = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_tt,
  output logic [N_IN-1:0]      stim,
  input  logic [N_IMPL-1:0]    f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   minterms,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_bad_idx,
  output logic                 first_bad_vld,
  output logic                 pass
);

  localparam int ROWS = 2**N_IN;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_settle;
  logic [N_IN-1:0]      r_stim;
  logic [ROWS-1:0]      r_exp;
  logic [ROWS-1:0]      r_minterms;
  logic [N_IN:0]        r_mm_cnt;
  logic [N_IN-1:0]      r_first_idx;
  logic                 r_first_vld;
  logic                 r_pass;

  logic                 w_start;
  logic                 w_sample;
  logic                 w_last;
  logic                 w_row_fail;
  logic [N_IN:0]        w_cnt_next;

  // A start is taken from IDLE, and also on the DONE cycle so that a start held
  // high launches the next sweep back-to-back with the previous one.
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_sample   = (r_state == S_DRIVE) && (r_settle == CW'(SETTLE - 1));
  assign w_last     = w_sample && (r_stim == N_IN'(ROWS - 1));
  assign w_row_fail = (f_in != {N_IMPL{f_in[0]}}) || (f_in[0] != r_exp[r_stim]);
  assign w_cnt_next = r_mm_cnt + (N_IN + 1)'(w_row_fail);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_DRIVE;
      S_DRIVE: if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = w_start ? S_DRIVE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_DRIVE: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Row stepping, settle counting and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle    <= '0;
      r_stim      <= '0;
      r_exp       <= '0;
      r_minterms  <= '0;
      r_mm_cnt    <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
      r_pass      <= 1'b0;
    end else if (w_start) begin
      r_settle    <= '0;
      r_stim      <= '0;
      r_exp       <= exp_tt;
      r_minterms  <= '0;
      r_mm_cnt    <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
      r_pass      <= 1'b0;
    end else if (w_sample) begin
      r_settle             <= '0;
      r_minterms[r_stim]   <= f_in[0];
      r_mm_cnt             <= w_cnt_next;
      if (w_row_fail && !r_first_vld) begin
        r_first_idx <= r_stim;
        r_first_vld <= 1'b1;
      end
      if (w_last) begin
        r_stim <= '0;
        r_pass <= (w_cnt_next == '0);
      end else begin
        r_stim <= r_stim + 1'b1;
      end
    end else if (r_state == S_DRIVE) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  assign stim          = r_stim;
  assign minterms      = r_minterms;
  assign mismatch_cnt  = r_mm_cnt;
  assign first_bad_idx = r_first_idx;
  assign first_bad_vld = r_first_vld;
  assign pass          = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one SETTLE=2 instance and one SETTLE=1 instance.
// Each implementation is modelled as a stored 8-row truth table indexed by stim.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Implementation tables shared by both instances
  logic [7:0] tbl [3];

  // SETTLE=2 instance
  logic       start_a = 1'b0;
  logic [7:0] exp_a   = 8'h00;
  logic [2:0] stim_a;
  logic [2:0] f_a;
  logic       busy_a, done_a, fbv_a, pass_a;
  logic [7:0] mt_a;
  logic [3:0] cnt_a;
  logic [2:0] fbi_a;

  // SETTLE=1 instance
  logic       start_b = 1'b0;
  logic [7:0] exp_b   = 8'h00;
  logic [2:0] stim_b;
  logic [2:0] f_b;
  logic       busy_b, done_b, fbv_b, pass_b;
  logic [7:0] mt_b;
  logic [3:0] cnt_b;
  logic [2:0] fbi_b;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      f_a[i] = tbl[i][stim_a];
      f_b[i] = tbl[i][stim_b];
    end
  end

  truth_table_sweeper #(.N_IN(3), .N_IMPL(3), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .exp_tt(exp_a), .stim(stim_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .minterms(mt_a), .mismatch_cnt(cnt_a),
    .first_bad_idx(fbi_a), .first_bad_vld(fbv_a), .pass(pass_a));

  truth_table_sweeper #(.N_IN(3), .N_IMPL(3), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .exp_tt(exp_b), .stim(stim_b), .f_in(f_b),
    .busy(busy_b), .done(done_b), .minterms(mt_b), .mismatch_cnt(cnt_b),
    .first_bad_idx(fbi_b), .first_bad_vld(fbv_b), .pass(pass_b));

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] F1 = 8'h5A;

  // Reference: evaluate every row from the tables directly
  function automatic void model(input logic [7:0] e, output logic [7:0] mt, output logic [3:0] cnt,
                                output logic [2:0] fbi, output logic fbv, output logic ok);
    mt = 8'h00; cnt = 4'd0; fbi = 3'd0; fbv = 1'b0;
    for (int r = 0; r < 8; r++) begin
      mt[r] = tbl[0][r];
      if (tbl[1][r] != tbl[0][r] || tbl[2][r] != tbl[0][r] || tbl[0][r] != e[r]) begin
        cnt++;
        if (!fbv) begin fbi = 3'(r); fbv = 1'b1; end
      end
    end
    ok = (cnt == 4'd0);
  endfunction

  // Full sweep on the SETTLE=2 instance with timing and result checks
  task automatic sweep_a(input string nm, input logic [7:0] e, input bit mid_change, input bit poke);
    logic [7:0] emt; logic [3:0] ecnt; logic [2:0] efbi; logic efbv, epass;
    model(e, emt, ecnt, efbi, efbv, epass);
    @(negedge clk); start_a = 1'b1; exp_a = e;
    @(negedge clk); start_a = 1'b0;
    for (int m = 0; m < 16; m++) begin
      checks++;
      if (busy_a !== 1'b1 || done_a !== 1'b0 || stim_a !== 3'(m / 2)) begin
        errors++;
        $display("FAIL %s_drive m=%0d: busy=%b done=%b stim=%0d, want busy=1 done=0 stim=%0d",
                 nm, m, busy_a, done_a, stim_a, m / 2);
      end
      if (mid_change && m == 3) exp_a = 8'h00;
      start_a = (poke && m == 5);
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || stim_a !== 3'd0) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b stim=%0d, want 1 0 0", nm, done_a, busy_a, stim_a);
    end
    checks++;
    if (mt_a !== emt || cnt_a !== ecnt || fbv_a !== efbv || pass_a !== epass || (efbv && fbi_a !== efbi)) begin
      errors++;
      $display("FAIL %s_result: mt=%h cnt=%0d fbi=%0d fbv=%b pass=%b, want mt=%h cnt=%0d fbi=%0d fbv=%b pass=%b",
               nm, mt_a, cnt_a, fbi_a, fbv_a, pass_a, emt, ecnt, efbi, efbv, epass);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || mt_a !== emt || cnt_a !== ecnt || pass_a !== epass) begin
      errors++;
      $display("FAIL %s_hold: done=%b busy=%b mt=%h cnt=%0d pass=%b, want 0 0 %h %0d %b",
               nm, done_a, busy_a, mt_a, cnt_a, pass_a, emt, ecnt, epass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({stim_a, busy_a, done_a, mt_a, cnt_a, fbi_a, fbv_a, pass_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: stim=%0d busy=%b done=%b mt=%h cnt=%0d fbi=%0d fbv=%b pass=%b, want all 0",
               stim_a, busy_a, done_a, mt_a, cnt_a, fbi_a, fbv_a, pass_a);
    end
    checks++;
    if ({stim_b, busy_b, done_b, mt_b, cnt_b, fbi_b, fbv_b, pass_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: stim=%0d busy=%b done=%b mt=%h cnt=%0d pass=%b, want all 0",
               stim_b, busy_b, done_b, mt_b, cnt_b, pass_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_correct();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = F1;
    sweep_a("correct", F1, 1'b0, 1'b0);
  endtask

  task automatic test_impl_fault();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = 8'h00;
    sweep_a("impl2_zero", F1, 1'b0, 1'b0);
  endtask

  task automatic test_exp_mismatch();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = F1;
    sweep_a("exp_5b", 8'h5B, 1'b0, 1'b0);
  endtask

  task automatic test_exp_latched();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = F1;
    sweep_a("exp_latched", F1, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    tbl[0] = F1; tbl[1] = 8'hFF; tbl[2] = F1;
    sweep_a("start_busy", F1, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL start_not_queued: busy=%b, want 0", busy_a);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] e;
      tbl[0] = ($urandom_range(0, 1) == 0) ? F1 : 8'($urandom);
      tbl[1] = tbl[0] ^ (($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      tbl[2] = tbl[0] ^ (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
      e      = ($urandom_range(0, 1) == 0) ? tbl[0] : 8'($urandom);
      sweep_a($sformatf("rand%0d", n), e, 1'b0, 1'b0);
    end
  endtask

  task automatic test_held_start();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = F1;
    @(negedge clk); start_a = 1'b1; exp_a = F1;
    for (int m = 0; m < 40; m++) begin
      logic eb, ed;
      @(negedge clk);
      ed = (m == 16 || m == 33);
      eb = (m < 16) || (m >= 17 && m < 33) || (m >= 34);
      checks++;
      if (busy_a !== eb || done_a !== ed) begin
        errors++;
        $display("FAIL held_start m=%0d: busy=%b done=%b, want busy=%b done=%b", m, busy_a, done_a, eb, ed);
      end
      if (m == 33) begin
        checks++;
        if (mt_a !== F1 || pass_a !== 1'b1 || cnt_a !== 4'd0) begin
          errors++;
          $display("FAIL held_result: mt=%h pass=%b cnt=%0d, want 5a 1 0", mt_a, pass_a, cnt_a);
        end
      end
    end
    start_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rst_mid();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = 8'h00;
    @(negedge clk); start_a = 1'b1; exp_a = F1;
    @(negedge clk); start_a = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (stim_a !== 3'd4 || busy_a !== 1'b1 || cnt_a !== 4'd2) begin
      errors++;
      $display("FAIL rst_mid_pre: stim=%0d busy=%b cnt=%0d, want 4 1 2", stim_a, busy_a, cnt_a);
    end
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({stim_a, busy_a, done_a, mt_a, cnt_a, fbi_a, fbv_a, pass_a} !== '0) begin
      errors++;
      $display("FAIL rst_mid: stim=%0d busy=%b done=%b mt=%h cnt=%0d fbi=%0d fbv=%b pass=%b, want all 0",
               stim_a, busy_a, done_a, mt_a, cnt_a, fbi_a, fbv_a, pass_a);
    end
    rst = 1'b0; start_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || stim_a !== 3'd0) begin
      errors++;
      $display("FAIL rst_idle: busy=%b stim=%0d, want 0 0", busy_a, stim_a);
    end
  endtask

  task automatic test_settle1();
    tbl[0] = F1; tbl[1] = F1; tbl[2] = F1;
    @(negedge clk); start_b = 1'b1; exp_b = F1;
    @(negedge clk); start_b = 1'b0;
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (busy_b !== 1'b1 || done_b !== 1'b0 || stim_b !== 3'(m)) begin
        errors++;
        $display("FAIL settle1_drive m=%0d: busy=%b done=%b stim=%0d, want 1 0 %0d", m, busy_b, done_b, stim_b, m);
      end
      @(negedge clk);
    end
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || mt_b !== F1 || cnt_b !== 4'd0 || pass_b !== 1'b1 || fbv_b !== 1'b0) begin
      errors++;
      $display("FAIL settle1_done: done=%b busy=%b mt=%h cnt=%0d pass=%b fbv=%b, want 1 0 5a 0 1 0",
               done_b, busy_b, mt_b, cnt_b, pass_b, fbv_b);
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL settle1_after: done=%b busy=%b, want 0 0", done_b, busy_b);
    end
  endtask

  initial begin
    tbl[0] = F1; tbl[1] = F1; tbl[2] = F1;
    test_reset();
    test_correct();
    test_impl_fault();
    test_exp_mismatch();
    test_exp_latched();
    test_start_ignored();
    test_random();
    test_held_start();
    test_rst_mid();
    test_settle1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
